// File: rtl/mem_access_unit.sv
// mem_access_unit
//   MEM-stage access unit sitting behind EX. Non-memory instructions are
//   passed straight through to write-back. Loads and stores run over a
//   req/ack data bus that may insert wait states; the unit stalls upstream
//   while an access is outstanding and aborts it after TIMEOUT_CYC cycles
//   without an ack.
//
// Ports
//   clk, reset            clock; synchronous active-high reset
//   ex_valid              EX/MEM slot holds a valid instruction
//   ALUout, RegB          address / ALU result, store data
//   MemRead, MemWrite     load / store (store wins when both are set)
//   MemSize, LoadSigned   00 word, 01 half, 10 byte, 11 word; load extension
//   RegWrite, WriteReg    destination control carried to write-back
//   stall                 combinational hold request to the upstream pipeline
//   bus_*                 registered data-memory request, ack and read data
//   wb_*                  registered write-back bundle, wb_valid pulses once
//   misalign, bus_err     one-cycle pulses: squashed access, timed-out access

module mem_access_unit #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [31:0] ALUout,
  input  logic [31:0] RegB,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  MemSize,
  input  logic        LoadSigned,
  input  logic        RegWrite,
  input  logic [4:0]  WriteReg,
  output logic        stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        wb_valid,
  output logic        wb_RegWrite,
  output logic [4:0]  wb_WriteReg,
  output logic [31:0] wb_data,
  output logic        misalign,
  output logic        bus_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      state_q, state_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [3:0]  bus_be_q, bus_be_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic        wb_valid_q, wb_valid_d;
  logic        wb_regwrite_q, wb_regwrite_d;
  logic [4:0]  wb_writereg_q, wb_writereg_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        misalign_q, misalign_d;
  logic        bus_err_q, bus_err_d;
  logic [1:0]  lo_q, lo_d;
  logic [1:0]  size_q, size_d;
  logic        sign_q, sign_d;
  logic        lat_regwrite_q, lat_regwrite_d;
  logic [4:0]  lat_writereg_q, lat_writereg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        mem_op;
  logic        misaligned_in;
  logic [3:0]  be_in;
  logic [31:0] wdata_in;
  logic [31:0] lane_word;
  logic [31:0] load_data;

  // Decode of the instruction currently presented by EX.
  always_comb begin
    mem_op = ex_valid & (MemRead | MemWrite);
    case (MemSize)
      2'b01: begin
        misaligned_in = ALUout[0];
        be_in         = ALUout[1] ? 4'b1100 : 4'b0011;
        wdata_in      = {2{RegB[15:0]}};
      end
      2'b10: begin
        misaligned_in = 1'b0;
        be_in         = 4'b0001 << ALUout[1:0];
        wdata_in      = {4{RegB[7:0]}};
      end
      default: begin
        misaligned_in = |ALUout[1:0];
        be_in         = 4'b1111;
        wdata_in      = RegB;
      end
    endcase
  end

  // Load formatting works from the latched lane offset so inputs can change
  // freely while the access is in flight.
  always_comb begin
    lane_word = bus_rdata >> {lo_q, 3'b000};
    case (size_q)
      2'b01:   load_data = {{16{sign_q & lane_word[15]}}, lane_word[15:0]};
      2'b10:   load_data = {{24{sign_q & lane_word[7]}}, lane_word[7:0]};
      default: load_data = bus_rdata;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    bus_req_d      = bus_req_q;
    bus_we_d       = bus_we_q;
    bus_addr_d     = bus_addr_q;
    bus_be_d       = bus_be_q;
    bus_wdata_d    = bus_wdata_q;
    lo_d           = lo_q;
    size_d         = size_q;
    sign_d         = sign_q;
    lat_regwrite_d = lat_regwrite_q;
    lat_writereg_d = lat_writereg_q;
    cnt_d          = cnt_q;
    wb_valid_d     = 1'b0;
    wb_regwrite_d  = 1'b0;
    wb_writereg_d  = 5'd0;
    wb_data_d      = 32'd0;
    misalign_d     = 1'b0;
    bus_err_d      = 1'b0;
    stall          = 1'b0;

    case (state_q)
      IDLE: begin
        if (mem_op) begin
          if (misaligned_in) begin
            misalign_d = 1'b1;
          end else begin
            stall          = 1'b1;
            state_d        = ACCESS;
            bus_req_d      = 1'b1;
            bus_we_d       = MemWrite;
            bus_addr_d     = {ALUout[31:2], 2'b00};
            bus_be_d       = be_in;
            bus_wdata_d    = wdata_in;
            lo_d           = ALUout[1:0];
            size_d         = MemSize;
            sign_d         = LoadSigned;
            lat_regwrite_d = RegWrite;
            lat_writereg_d = WriteReg;
            cnt_d          = '0;
          end
        end else if (ex_valid) begin
          wb_valid_d    = 1'b1;
          wb_regwrite_d = RegWrite;
          wb_writereg_d = WriteReg;
          wb_data_d     = ALUout;
        end
      end
      ACCESS: begin
        // An ack arriving in the final timeout cycle still completes the access.
        if (bus_ack) begin
          state_d       = IDLE;
          bus_req_d     = 1'b0;
          bus_we_d      = 1'b0;
          bus_addr_d    = 32'd0;
          bus_be_d      = 4'd0;
          bus_wdata_d   = 32'd0;
          wb_valid_d    = 1'b1;
          wb_regwrite_d = lat_regwrite_q;
          wb_writereg_d = lat_writereg_q;
          wb_data_d     = bus_we_q ? 32'd0 : load_data;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          state_d     = IDLE;
          bus_req_d   = 1'b0;
          bus_we_d    = 1'b0;
          bus_addr_d  = 32'd0;
          bus_be_d    = 4'd0;
          bus_wdata_d = 32'd0;
          bus_err_d   = 1'b1;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      bus_req_q      <= 1'b0;
      bus_we_q       <= 1'b0;
      bus_addr_q     <= 32'd0;
      bus_be_q       <= 4'd0;
      bus_wdata_q    <= 32'd0;
      wb_valid_q     <= 1'b0;
      wb_regwrite_q  <= 1'b0;
      wb_writereg_q  <= 5'd0;
      wb_data_q      <= 32'd0;
      misalign_q     <= 1'b0;
      bus_err_q      <= 1'b0;
      lo_q           <= 2'd0;
      size_q         <= 2'd0;
      sign_q         <= 1'b0;
      lat_regwrite_q <= 1'b0;
      lat_writereg_q <= 5'd0;
      cnt_q          <= '0;
    end else begin
      state_q        <= state_d;
      bus_req_q      <= bus_req_d;
      bus_we_q       <= bus_we_d;
      bus_addr_q     <= bus_addr_d;
      bus_be_q       <= bus_be_d;
      bus_wdata_q    <= bus_wdata_d;
      wb_valid_q     <= wb_valid_d;
      wb_regwrite_q  <= wb_regwrite_d;
      wb_writereg_q  <= wb_writereg_d;
      wb_data_q      <= wb_data_d;
      misalign_q     <= misalign_d;
      bus_err_q      <= bus_err_d;
      lo_q           <= lo_d;
      size_q         <= size_d;
      sign_q         <= sign_d;
      lat_regwrite_q <= lat_regwrite_d;
      lat_writereg_q <= lat_writereg_d;
      cnt_q          <= cnt_d;
    end
  end

  assign bus_req     = bus_req_q;
  assign bus_we      = bus_we_q;
  assign bus_addr    = bus_addr_q;
  assign bus_be      = bus_be_q;
  assign bus_wdata   = bus_wdata_q;
  assign wb_valid    = wb_valid_q;
  assign wb_RegWrite = wb_regwrite_q;
  assign wb_WriteReg = wb_writereg_q;
  assign wb_data     = wb_data_q;
  assign misalign    = misalign_q;
  assign bus_err     = bus_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit
//   Drives directed and randomized instructions into mem_access_unit and
//   compares every output against a transaction-level model of the
//   MEM stage (byte counts, lane arithmetic, wait/timeout cycle counts).

module tb_mem_access_unit;

  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic [31:0] ALUout;
  logic [31:0] RegB;
  logic        MemRead;
  logic        MemWrite;
  logic [1:0]  MemSize;
  logic        LoadSigned;
  logic        RegWrite;
  logic [4:0]  WriteReg;
  logic        stall;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        wb_valid;
  logic        wb_RegWrite;
  logic [4:0]  wb_WriteReg;
  logic [31:0] wb_data;
  logic        misalign;
  logic        bus_err;

  int errors = 0;
  int checks = 0;

  mem_access_unit #(.TIMEOUT_CYC(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ALUout(ALUout), .RegB(RegB),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemSize(MemSize), .LoadSigned(LoadSigned),
    .RegWrite(RegWrite), .WriteReg(WriteReg), .stall(stall), .bus_req(bus_req),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .wb_valid(wb_valid),
    .wb_RegWrite(wb_RegWrite), .wb_WriteReg(wb_WriteReg), .wb_data(wb_data),
    .misalign(misalign), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Model: number of bytes moved by an access of the given size code.
  function automatic int sizeBytes(input logic [1:0] sz);
    if (sz == 2'b01) return 2;
    if (sz == 2'b10) return 1;
    return 4;
  endfunction

  function automatic logic [3:0] modelBe(input logic [31:0] a, input int n);
    int lane = int'(a[1:0]);
    int be = ((1 << n) - 1) << lane;
    return be[3:0];
  endfunction

  // Each lane carries the store byte whose index is the lane modulo access width.
  function automatic logic [31:0] modelWdata(input logic [31:0] b, input int n);
    logic [31:0] w = 32'd0;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = b[8*(i % n) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] modelLoad(input logic [31:0] w, input logic [31:0] a, input int n, input logic sgn);
    longint unsigned mask = (64'd1 << (8 * n)) - 64'd1;
    longint unsigned val = ({32'd0, w} >> (8 * int'(a[1:0]))) & mask;
    if (sgn && (((val >> (8 * n - 1)) & 64'd1) != 64'd0)) val = val | ~mask;
    return val[31:0];
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic scrambleInputs();
    ex_valid   = 1'($urandom);
    ALUout     = $urandom;
    RegB       = $urandom;
    MemRead    = 1'($urandom);
    MemWrite   = 1'($urandom);
    MemSize    = 2'($urandom);
    LoadSigned = 1'($urandom);
    RegWrite   = 1'($urandom);
    WriteReg   = 5'($urandom);
  endtask

  // One instruction from presentation to retirement; enters and leaves at a negedge.
  task automatic applyStimulus(input logic v, input logic rd, input logic wr, input logic [1:0] sz,
                               input logic sgn, input logic rw, input logic [4:0] rdst,
                               input logic [31:0] a, input logic [31:0] b, input int waits,
                               input logic giveAck, input logic [31:0] rdata);
    int n;
    logic isMem, mis, ackNow, expStall;
    int limit;
    logic [31:0] expAddr;
    n       = sizeBytes(sz);
    isMem   = v && (rd || wr);
    mis     = isMem && ((a % n) != 0);
    expAddr = a - (a % 4);
    ex_valid = v; MemRead = rd; MemWrite = wr; MemSize = sz; LoadSigned = sgn;
    RegWrite = rw; WriteReg = rdst; ALUout = a; RegB = b;
    bus_ack = isMem ? 1'b0 : 1'($urandom); bus_rdata = $urandom;
    #1;
    checkOutput("stall_idle", 32'(stall), 32'(isMem && !mis));
    checkOutput("req_idle", 32'(bus_req), 32'd0);
    if (!isMem || mis) begin
      step();
      checkOutput("wb_valid", 32'(wb_valid), 32'(v && !isMem));
      checkOutput("misalign", 32'(misalign), 32'(mis));
      checkOutput("req_after", 32'(bus_req), 32'd0);
      if (v && !isMem) begin
        checkOutput("wb_data_alu", wb_data, a);
        checkOutput("wb_rw_alu", 32'(wb_RegWrite), 32'(rw));
        checkOutput("wb_rd_alu", 32'(wb_WriteReg), 32'(rdst));
      end
      bus_ack = 1'b0;
      return;
    end
    step();
    limit = giveAck ? waits + 1 : TIMEOUT;
    for (int k = 0; k < limit; k++) begin
      checkOutput("bus_req", 32'(bus_req), 32'd1);
      checkOutput("bus_we", 32'(bus_we), 32'(wr));
      checkOutput("bus_addr", bus_addr, expAddr);
      checkOutput("bus_be", 32'(bus_be), 32'(modelBe(a, n)));
      if (wr) checkOutput("bus_wdata", bus_wdata, modelWdata(b, n));
      checkOutput("wb_valid_wait", 32'(wb_valid), 32'd0);
      scrambleInputs();
      ackNow = giveAck && (k == waits);
      bus_ack = ackNow;
      bus_rdata = ackNow ? rdata : $urandom;
      expStall = !(ackNow || (k == TIMEOUT - 1));
      #1;
      checkOutput("stall_acc", 32'(stall), 32'(expStall));
      step();
    end
    bus_ack = 1'b0;
    checkOutput("req_done", 32'(bus_req), 32'd0);
    checkOutput("misalign_mem", 32'(misalign), 32'd0);
    if (giveAck) begin
      checkOutput("wb_valid_mem", 32'(wb_valid), 32'd1);
      checkOutput("bus_err_ok", 32'(bus_err), 32'd0);
      checkOutput("wb_data_mem", wb_data, wr ? 32'd0 : modelLoad(rdata, a, n, sgn));
      checkOutput("wb_rw_mem", 32'(wb_RegWrite), 32'(rw));
      checkOutput("wb_rd_mem", 32'(wb_WriteReg), 32'(rdst));
    end else begin
      checkOutput("bus_err", 32'(bus_err), 32'd1);
      checkOutput("wb_valid_to", 32'(wb_valid), 32'd0);
      ex_valid = 1'b0;
      bus_ack = 1'b1;
      bus_rdata = $urandom;
      step();
      checkOutput("late_ack_wb", 32'(wb_valid), 32'd0);
      checkOutput("late_ack_req", 32'(bus_req), 32'd0);
      checkOutput("late_ack_err", 32'(bus_err), 32'd0);
      bus_ack = 1'b0;
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_req"}, 32'(bus_req), 32'd0);
    checkOutput({tag, "_we"}, 32'(bus_we), 32'd0);
    checkOutput({tag, "_addr"}, bus_addr, 32'd0);
    checkOutput({tag, "_be"}, 32'(bus_be), 32'd0);
    checkOutput({tag, "_wdata"}, bus_wdata, 32'd0);
    checkOutput({tag, "_wbv"}, 32'(wb_valid), 32'd0);
    checkOutput({tag, "_wbrw"}, 32'(wb_RegWrite), 32'd0);
    checkOutput({tag, "_wbrd"}, 32'(wb_WriteReg), 32'd0);
    checkOutput({tag, "_wbdata"}, wb_data, 32'd0);
    checkOutput({tag, "_mis"}, 32'(misalign), 32'd0);
    checkOutput({tag, "_err"}, 32'(bus_err), 32'd0);
    checkOutput({tag, "_stall"}, 32'(stall), 32'd0);
  endtask

  initial begin
    int kind, n, waits;
    logic [1:0] sz;
    logic [31:0] a;
    logic rd, wr, ack;

    reset = 1'b1; ex_valid = 1'b0; ALUout = 32'd0; RegB = 32'd0; MemRead = 1'b0;
    MemWrite = 1'b0; MemSize = 2'd0; LoadSigned = 1'b0; RegWrite = 1'b0; WriteReg = 5'd0;
    bus_ack = 1'b0; bus_rdata = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkAllZero("reset");
    reset = 1'b0;

    $display("[TB] directed cases");
    applyStimulus(1, 0, 0, 2'b00, 0, 1, 5'd3, 32'h0000_1234, 32'h0, 0, 1, 32'h0);
    applyStimulus(1, 1, 0, 2'b00, 0, 1, 5'd4, 32'h0000_0100, 32'h0, 3, 1, 32'hDEAD_BEEF);
    applyStimulus(1, 1, 0, 2'b10, 1, 1, 5'd5, 32'h0000_0103, 32'h0, 0, 1, 32'h80FF_FFFF);
    applyStimulus(1, 1, 0, 2'b10, 0, 1, 5'd6, 32'h0000_0103, 32'h0, 1, 1, 32'h80FF_FFFF);
    applyStimulus(1, 0, 1, 2'b01, 0, 0, 5'd0, 32'h0000_0102, 32'hAAAA_5678, 2, 1, 32'h0);
    applyStimulus(1, 1, 1, 2'b11, 0, 0, 5'd0, 32'h0000_0204, 32'h1357_9BDF, 0, 1, 32'hFFFF_FFFF);
    applyStimulus(1, 1, 0, 2'b00, 0, 1, 5'd7, 32'h0000_0101, 32'h0, 0, 1, 32'h0);
    applyStimulus(1, 1, 0, 2'b01, 1, 1, 5'd8, 32'h0000_0202, 32'h0, 0, 1, 32'h8001_7FFF);
    applyStimulus(1, 1, 0, 2'b00, 0, 1, 5'd9, 32'h0000_0300, 32'h0, 0, 0, 32'h0);
    applyStimulus(1, 1, 0, 2'b00, 0, 1, 5'd10, 32'h0000_0304, 32'h0, TIMEOUT - 1, 1, 32'h0BAD_F00D);

    $display("[TB] reset during access");
    ex_valid = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; MemSize = 2'b00; ALUout = 32'h0000_0400;
    step();
    step();
    checkOutput("pre_reset_req", 32'(bus_req), 32'd1);
    reset = 1'b1; ex_valid = 1'b0;
    step();
    reset = 1'b0;
    #1;
    checkAllZero("midrst");
    bus_ack = 1'b1; bus_rdata = 32'h1111_2222;
    step();
    checkOutput("midrst_late_wb", 32'(wb_valid), 32'd0);
    checkOutput("midrst_late_req", 32'(bus_req), 32'd0);
    bus_ack = 1'b0;

    $display("[TB] randomized traffic");
    for (int i = 0; i < 150; i++) begin
      kind = $urandom_range(0, 9);
      sz = 2'($urandom);
      n = sizeBytes(sz);
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a = a - (a % n);
      rd = (kind >= 4 && kind <= 6) || kind == 9 || (kind <= 1 && $urandom_range(0, 1) == 1);
      wr = (kind >= 7);
      waits = $urandom_range(0, 4);
      ack = ($urandom_range(0, 24) != 0);
      applyStimulus(kind >= 2, rd, wr, sz, 1'($urandom), 1'($urandom), 5'($urandom),
                    a, $urandom, waits, ack, $urandom);
    end

    ex_valid = 1'b0;
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
